// File: rtl/fast_control_seq.sv
// Fast-control command sequencer: BX/orbit counter, gated L1A, periodic and calibration triggers.
// Latency: a request seen in cycle N appears in fc_word at N+1 and in fc_stream_enc at N+2.
// Backpressure: none; L1A requests arriving inside the minimum gap are dropped and counted.
//
// Ports:
//   clk_bx, reset (sync, active high)
//   orb_length, calib_bx, calib_len, calib_l1a_offset : orbit and calibration configuration
//   req_l1a, req_link_reset, req_buffer_clear, req_calib : single-cycle request pulses
//   periodic_en, periodic_period, l1a_min_gap, aux_bits  : trigger configuration and debug bits
//   fc_word, fc_stream_enc, bx_id                        : command word, Hamming stream, current BX
//   l1a_count, l1a_drop_count, calib_busy                : statistics and status
module fast_control_seq #(
  parameter int NUM_NIBBLES = 2,
  parameter int ORB_W       = 12,
  parameter int GAP_W       = 8,
  parameter int CNT_W       = 32,
  localparam int W          = 4 * NUM_NIBBLES
) (
  input  logic               clk_bx,
  input  logic               reset,
  input  logic [ORB_W-1:0]   orb_length,
  input  logic [ORB_W-1:0]   calib_bx,
  input  logic [3:0]         calib_len,
  input  logic [7:0]         calib_l1a_offset,
  input  logic               req_l1a,
  input  logic               req_link_reset,
  input  logic               req_buffer_clear,
  input  logic               req_calib,
  input  logic               periodic_en,
  input  logic [15:0]        periodic_period,
  input  logic [GAP_W-1:0]   l1a_min_gap,
  input  logic [W-6:0]       aux_bits,
  output logic [W-1:0]       fc_word,
  output logic [2*W-1:0]     fc_stream_enc,
  output logic [ORB_W-1:0]   bx_id,
  output logic [CNT_W-1:0]   l1a_count,
  output logic [CNT_W-1:0]   l1a_drop_count,
  output logic               calib_busy
);

  typedef enum logic [1:0] {CAL_IDLE, CAL_ARMED, CAL_ACTIVE} cal_state_t;

  // Hamming(8,4): bits[6:0] = {d3,d2,d1,p3,d0,p2,p1}, bit7 = overall parity.
  function automatic logic [7:0] hamming84_enc(input logic [3:0] d);
    logic p1, p2, p3;
    logic [6:0] c;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    c  = {d[3], d[2], d[1], p3, d[0], p2, p1};
    return {^c, c};
  endfunction

  logic [ORB_W-1:0] bx_cnt;
  logic [ORB_W-1:0] bx_inc;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      per_cnt;
  logic             per_run;
  logic             per_active;
  logic             per_fire;
  cal_state_t       cal_state, cal_state_nxt;
  logic [7:0]       cal_cyc, cal_cyc_nxt;
  logic             cal_pulse, cal_l1a;
  logic [3:0]       cal_len_m;
  logic             l1a_req, l1a_issue, l1a_drop;
  logic [W-1:0]     word_nxt;
  logic [2*W-1:0]   enc_nxt;

  // BX counter; orb_length==0 wraps naturally because bx_inc overflows to 0.
  assign bx_inc = bx_cnt + ORB_W'(1);
  assign bx_id  = bx_cnt;

  always_ff @(posedge clk_bx) begin
    if (reset) bx_cnt <= '0;
    else       bx_cnt <= (bx_inc == orb_length) ? '0 : bx_inc;
  end

  // Periodic generator. per_run marks that the generator was already running
  // last cycle, so the first cycle of a run only loads the count.
  assign per_active = periodic_en && (periodic_period != 16'd0);
  assign per_fire   = per_active && per_run && (per_cnt == 16'd0);

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      per_cnt <= '0;
      per_run <= 1'b0;
    end else begin
      per_run <= per_active;
      if (!per_active || !per_run || per_fire) per_cnt <= periodic_period - 16'd1;
      else                                     per_cnt <= per_cnt - 16'd1;
    end
  end

  // Calibration FSM. cal_cyc counts ACTIVE cycles from the pulse start.
  assign cal_len_m  = (calib_len == 4'd0) ? 4'd1 : calib_len;
  assign calib_busy = (cal_state != CAL_IDLE);

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      cal_state <= CAL_IDLE;
      cal_cyc   <= '0;
    end else begin
      cal_state <= cal_state_nxt;
      cal_cyc   <= cal_cyc_nxt;
    end
  end

  always_comb begin
    cal_state_nxt = cal_state;
    cal_cyc_nxt   = cal_cyc;
    cal_pulse     = 1'b0;
    cal_l1a       = 1'b0;
    case (cal_state)
      CAL_IDLE: begin
        cal_cyc_nxt = '0;
        if (req_calib) cal_state_nxt = CAL_ARMED;
      end
      CAL_ARMED: begin
        cal_cyc_nxt = '0;
        if (bx_cnt == calib_bx) cal_state_nxt = CAL_ACTIVE;
      end
      CAL_ACTIVE: begin
        cal_pulse = (cal_cyc < {4'd0, cal_len_m});
        cal_l1a   = (calib_l1a_offset != 8'd0) && (cal_cyc == calib_l1a_offset);
        // Leave once both the pulse and the delayed L1A are behind us.
        if ((cal_cyc >= ({4'd0, cal_len_m} - 8'd1)) &&
            ((calib_l1a_offset == 8'd0) || (cal_cyc >= calib_l1a_offset))) begin
          cal_state_nxt = CAL_IDLE;
          cal_cyc_nxt   = '0;
        end else begin
          cal_cyc_nxt = cal_cyc + 8'd1;
        end
      end
      default: cal_state_nxt = CAL_IDLE;
    endcase
  end

  // L1A arbitration: all sources merge into one request, gated by the gap counter.
  assign l1a_req   = req_l1a | cal_l1a | per_fire;
  assign l1a_issue = l1a_req && (gap_cnt == '0);
  assign l1a_drop  = l1a_req && (gap_cnt != '0);

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      gap_cnt        <= '0;
      l1a_count      <= '0;
      l1a_drop_count <= '0;
    end else begin
      if (l1a_issue)           gap_cnt <= l1a_min_gap;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);
      if (l1a_issue && (l1a_count != '1))      l1a_count      <= l1a_count + CNT_W'(1);
      if (l1a_drop && (l1a_drop_count != '1))  l1a_drop_count <= l1a_drop_count + CNT_W'(1);
    end
  end

  // Command word assembly; aux_bits[0] sits below CALIB, the rest above it.
  always_comb begin
    word_nxt    = '0;
    word_nxt[0] = (bx_cnt == '0);
    word_nxt[1] = l1a_issue;
    word_nxt[2] = req_link_reset;
    word_nxt[3] = req_buffer_clear;
    word_nxt[4] = aux_bits[0];
    word_nxt[5] = cal_pulse;
    for (int k = 1; k <= W - 6; k++) word_nxt[5 + k] = aux_bits[k];
  end

  always_comb begin
    enc_nxt = '0;
    for (int i = 0; i < NUM_NIBBLES; i++) enc_nxt[8*i +: 8] = hamming84_enc(fc_word[4*i +: 4]);
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      fc_word       <= '0;
      fc_stream_enc <= '0;
    end else begin
      fc_word       <= word_nxt;
      fc_stream_enc <= enc_nxt;
    end
  end

endmodule

// File: doc/fast_control_seq.md
FAST_CONTROL_SEQ -- requirements
Module: fast_control_seq

Interface
REQ-001 Parameter NUM_NIBBLES, default 2, SHALL set command word width W=4*NUM_NIBBLES (legal values 2..4).
REQ-002 Parameter ORB_W, default 12, SHALL set BX counter and orbit-length width.
REQ-003 Parameter GAP_W, default 8, SHALL set minimum-L1A-gap width.
REQ-004 Parameter CNT_W, default 32, SHALL set statistics counter width.
REQ-005 Ports SHALL be, clock and reset first: clk_bx in 1 BX clock, sole clock; reset in 1 synchronous active-high reset.
REQ-006 orb_length in ORB_W orbit length in BX; calib_bx in ORB_W BX phase for calib pulse; calib_len in 4 calib pulse length; calib_l1a_offset in 8 calib-to-L1A delay.
REQ-007 req_l1a, req_link_reset, req_buffer_clear, req_calib in 1 each: single-cycle request pulses, already in clk_bx domain.
REQ-008 periodic_en in 1; periodic_period in 16; l1a_min_gap in GAP_W; aux_bits in W-5 quasi-static debug bits.
REQ-009 fc_word out W raw command word; fc_stream_enc out 2W Hamming-encoded word; bx_id out ORB_W current BX.
REQ-010 l1a_count out CNT_W issued L1As; l1a_drop_count out CNT_W dropped L1A requests; calib_busy out 1 calib FSM not IDLE.

Function
REQ-011 BX counter SHALL increment each cycle and wrap to 0 when counter+1 equals orb_length; orb_length=0 SHALL mean wrap at 2^ORB_W; bx_id SHALL equal the counter.
REQ-012 fc_word SHALL be registered: bit0 BCR (counter==0), bit1 L1A, bit2 LINK_RESET, bit3 BUFFER_CLEAR, bit4 aux_bits[0], bit5 CALIB, bit(5+k) aux_bits[k] for k>=1.
REQ-013 Request pulse at cycle N SHALL appear in fc_word at N+1 and in fc_stream_enc at N+2.
REQ-014 fc_stream_enc nibble i SHALL be the hamming84_enc encoding of fc_word[4i+3:4i], placed at bits [8i+7:8i], registered one cycle after fc_word.
REQ-015 L1A request SHALL be the OR of req_l1a, calib L1A, periodic L1A; simultaneous sources SHALL count as one request.
REQ-016 A gap counter, reset 0, SHALL load l1a_min_gap when an L1A is issued and otherwise decrement to 0.
REQ-017 An L1A request SHALL be issued only when the gap counter is 0; otherwise it SHALL be dropped and l1a_drop_count incremented.
REQ-018 l1a_min_gap=0 SHALL allow L1A every cycle.
REQ-019 l1a_count and l1a_drop_count SHALL saturate at all-ones.
REQ-020 Periodic generator: with periodic_en=1 and periodic_period=P>0, a down-counter SHALL request an L1A every P cycles, the first P cycles after enable rises.
REQ-021 periodic_en=0 or P=0 SHALL hold the periodic counter at reload value and request nothing.
REQ-022 Calib FSM states SHALL be IDLE, ARMED, ACTIVE.
REQ-023 IDLE->ARMED on req_calib; req_calib in ARMED or ACTIVE SHALL be ignored.
REQ-024 ARMED->ACTIVE in the cycle after the BX counter equals calib_bx; pulse start S is the first ACTIVE cycle.
REQ-025 CALIB bit SHALL request high for max(calib_len,1) cycles beginning at S.
REQ-026 With calib_l1a_offset=D>0, a calib L1A request SHALL be raised at cycle S+D, independent of pulse length; D=0 SHALL produce no calib L1A.
REQ-027 ACTIVE->IDLE once the pulse has ended and the calib L1A (if any) has been requested, whichever is later.
REQ-028 calib_busy SHALL be high in ARMED and ACTIVE.
REQ-029 LINK_RESET and BUFFER_CLEAR SHALL follow their request pulses one-for-one with no gap rule.

Reset
REQ-030 While reset=1: BX counter, gap counter, periodic counter, statistics counters, fc_word, fc_stream_enc SHALL be 0, and FSM SHALL be IDLE.
REQ-031 Reset asserted mid-calib or mid-gap SHALL abort the sequence; no pending pulse or L1A SHALL issue after release.
REQ-032 First cycle after reset release SHALL have bx_id=0 and BCR set in fc_word one cycle later.

Verification
REQ-033 orb_length=45, no requests -> BCR bit every 45 cycles, bx_id sequence 0..44 repeats; orb_length=0 -> wrap after 4096.
REQ-034 l1a_min_gap=3, req_l1a at cycles 10,11,13,14 -> L1A at 11 and 15 in fc_word; l1a_count=2, l1a_drop_count=2.
REQ-035 calib_bx=5, calib_len=2, calib_l1a_offset=20, req_calib at bx 30 -> CALIB bit two cycles starting one cycle after next bx=5, L1A 20 cycles after pulse start; second req_calib while busy ignored.
REQ-036 periodic_en=1, P=10, min_gap=0, 100 cycles -> exactly 10 L1As 10 cycles apart; simultaneous req_l1a on a periodic cycle -> single L1A, no drop.
REQ-037 NUM_NIBBLES=3, random fc_word -> each fc_stream_enc byte equals hamming84_enc of its nibble two cycles after request.
REQ-038 reset pulsed during ACTIVE with pending calib L1A -> no L1A after release, all counters 0, calib_busy=0.
